// File: rtl/apb_master.sv
// apb_master: APB3 master that converts a valid/ready command stream into
// SETUP/ACCESS bus transfers and returns a one-cycle response pulse.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT consecutive wait states (response flagged as an error).
module apb_master #(
    parameter int AWIDTH  = 4,
    parameter int DWIDTH  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [AWIDTH-1:0] paddr,
    output logic [DWIDTH-1:0] pwdata,
    input  logic [DWIDTH-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [AWIDTH-1:0] paddr_q, paddr_d;
    logic [DWIDTH-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DWIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
`endif

    // The master can only take a new command while the bus is idle.
    assign cmd_ready = (state_q == IDLE);

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Next-state and registered-output computation for the APB sequence.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = cmd_write;
                    paddr_d   = cmd_addr;
                    if (cmd_write) begin
                        pwdata_d = cmd_wdata;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    wait_cnt_d = '0;
`endif
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (wait_cnt_q == CW'(TIMEOUT)) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d   = IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight transfer.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    // Wait-state counter register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed bench for apb_master with a transaction-level
// reference model checked on every falling clock edge.
module tb_apb_master;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TB_TIMEOUT = 4;

    logic          pclk = 1'b0;
    logic          presetn = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = '0;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    int checks = 0;
    int failures = 0;

    apb_master #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(TB_TIMEOUT)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transfer is "busy" from acceptance until the edge that
    // completes it; the first busy cycle is the setup phase, the rest are access.
    logic          m_busy, m_access, m_pwrite, m_rsp_valid, m_err;
    logic [AW-1:0] m_paddr;
    logic [DW-1:0] m_pwdata, m_rdata;
    int            m_waits;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            m_busy <= 1'b0; m_access <= 1'b0; m_pwrite <= 1'b0; m_rsp_valid <= 1'b0;
            m_err <= 1'b0; m_paddr <= '0; m_pwdata <= '0; m_rdata <= '0; m_waits <= 0;
        end else begin
            m_rsp_valid <= 1'b0;
            if (!m_busy) begin
                if (cmd_valid) begin
                    m_busy <= 1'b1; m_access <= 1'b0; m_waits <= 0;
                    m_paddr <= cmd_addr; m_pwrite <= cmd_write;
                    if (cmd_write) m_pwdata <= cmd_wdata;
                end
            end else if (!m_access) begin
                m_access <= 1'b1;
            end else if (pready) begin
                m_busy <= 1'b0; m_access <= 1'b0; m_rsp_valid <= 1'b1;
                m_err <= pslverr; m_rdata <= m_pwrite ? '0 : prdata;
            end
`ifdef APB_MASTER_TIMEOUT_EN
            else if (m_waits == TB_TIMEOUT) begin
                m_busy <= 1'b0; m_access <= 1'b0; m_rsp_valid <= 1'b1;
                m_err <= 1'b1; m_rdata <= '0;
            end
`endif
            else begin
                m_waits <= m_waits + 1;
            end
        end
    end

    // Per-cycle compare of every DUT output against the model.
    always @(negedge pclk) begin
        checkOutput("cyc_cmd_ready", cmd_ready, !m_busy);
        checkOutput("cyc_psel", psel, m_busy);
        checkOutput("cyc_penable", penable, m_access);
        checkOutput("cyc_pwrite", pwrite, m_pwrite);
        checkOutput("cyc_paddr", paddr, m_paddr);
        checkOutput("cyc_pwdata", pwdata, m_pwdata);
        checkOutput("cyc_rsp_valid", rsp_valid, m_rsp_valid);
        checkOutput("cyc_rsp_rdata", rsp_rdata, m_rdata);
        checkOutput("cyc_rsp_err", rsp_err, m_err);
    end

    // Bus activity counters and setup-phase address capture.
    int            psel_cnt = 0, pen_cnt = 0, rsp_cnt = 0;
    logic          capture_en = 1'b0;
    logic [AW-1:0] addr_q[$];

    always @(negedge pclk) begin
        psel_cnt <= psel_cnt + int'(psel);
        pen_cnt  <= pen_cnt + int'(penable);
        rsp_cnt  <= rsp_cnt + int'(rsp_valid);
        if (capture_en && psel && !penable) addr_q.push_back(paddr);
    end

    task automatic clearCounters();
        psel_cnt = 0; pen_cnt = 0; rsp_cnt = 0;
    endtask

    // Wait (bounded) for an idle master, then present one command for one edge.
    task automatic applyStimulus(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        int n;
        n = 0;
        @(negedge pclk);
        while (!cmd_ready && n < 50) begin
            @(negedge pclk);
            n++;
        end
        if (!cmd_ready) checkOutput("wait_cmd_ready", cmd_ready, 1);
        #1;
        clearCounters();
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        cmd_wdata = 8'hDD;
        pready = 1'b1; pslverr = 1'b1; prdata = 8'hEE;
    endtask

    // Full transfer with a given number of wait states; returns at E_done+1.
    task automatic doTransfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input int nwaits, input logic [DW-1:0] rd, input logic err);
        applyStimulus(wr, a, wd);
        @(posedge pclk); #1;
        pready = 1'b0; pslverr = !err; prdata = ~rd;
        repeat (nwaits) begin @(posedge pclk); #1; end
        pready = 1'b1; pslverr = err; prdata = rd;
        @(posedge pclk); #1;
        pready = 1'b0; pslverr = 1'b0; prdata = 8'h00;
    endtask

    // Assert reset in the middle of a cycle while a transfer is in ACCESS.
    task automatic resetMidAccess();
        @(posedge pclk); #3;
        presetn = 1'b0;
        #1;
        checkOutput("rst_psel", psel, 0);
        checkOutput("rst_penable", penable, 0);
        checkOutput("rst_pwrite", pwrite, 0);
        checkOutput("rst_paddr", paddr, 0);
        checkOutput("rst_pwdata", pwdata, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 0);
        checkOutput("rst_rsp_err", rsp_err, 0);
        checkOutput("rst_cmd_ready", cmd_ready, 1);
        @(negedge pclk); #1;
        presetn = 1'b1;
        clearCounters();
        repeat (6) @(negedge pclk);
        #1;
        checkOutput("rst_no_rsp", rsp_cnt, 0);
        checkOutput("rst_idle_ready", cmd_ready, 1);
    endtask

    // Directed sequence.
    initial begin
        int n, cyc;
        int acc_cyc[4];
        logic acc;

        #2 presetn = 1'b0;
        #1;
        checkOutput("init_psel", psel, 0);
        checkOutput("init_cmd_ready", cmd_ready, 1);
        checkOutput("init_rsp_valid", rsp_valid, 0);
        repeat (2) @(negedge pclk);
        #1 presetn = 1'b1;

        // Zero-wait write.
        doTransfer(1'b1, 4'h3, 8'hA5, 0, 8'h00, 1'b0);
        checkOutput("wr_psel_cycles", psel_cnt, 2);
        checkOutput("wr_penable_cycles", pen_cnt, 1);
        checkOutput("wr_rsp_valid", rsp_valid, 1);
        checkOutput("wr_rsp_err", rsp_err, 0);
        checkOutput("wr_rsp_rdata", rsp_rdata, 0);
        checkOutput("wr_paddr", paddr, 4'h3);
        checkOutput("wr_pwdata", pwdata, 8'hA5);
        checkOutput("wr_cmd_ready", cmd_ready, 1);

        // Read with three wait states.
        doTransfer(1'b0, 4'h7, 8'h11, 3, 8'h5C, 1'b0);
        checkOutput("rd_penable_cycles", pen_cnt, 4);
        checkOutput("rd_rsp_valid", rsp_valid, 1);
        checkOutput("rd_rsp_rdata", rsp_rdata, 8'h5C);
        checkOutput("rd_rsp_err", rsp_err, 0);
        checkOutput("rd_pwdata_held", pwdata, 8'hA5);

        // Slave error then a clean transfer.
        doTransfer(1'b1, 4'hF, 8'h3C, 1, 8'h00, 1'b1);
        checkOutput("err_rsp_err", rsp_err, 1);
        checkOutput("err_rsp_rdata", rsp_rdata, 0);
        doTransfer(1'b0, 4'h2, 8'h00, 0, 8'h81, 1'b0);
        checkOutput("good_rsp_err", rsp_err, 0);
        checkOutput("good_rsp_rdata", rsp_rdata, 8'h81);

        // Back-to-back with cmd_valid held high.
        addr_q.delete();
        capture_en = 1'b1;
        pready = 1'b1; pslverr = 1'b0;
        cmd_write = 1'b1; cmd_addr = 4'h0; cmd_wdata = 8'h10; cmd_valid = 1'b1;
        n = 0; cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge pclk);
            acc = cmd_ready;
            @(posedge pclk); #1;
            cyc++;
            if (acc) begin
                acc_cyc[n] = cyc;
                n++;
                if (n < 4) begin
                    cmd_addr = AW'(n);
                    cmd_wdata = DW'(8'h10 + n);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
        checkOutput("b2b_accepted", n, 4);
        for (int i = 1; i < 4; i++) checkOutput("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
        repeat (4) @(posedge pclk);
        #1;
        capture_en = 1'b0;
        pready = 1'b0;
        checkOutput("b2b_addr_count", addr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < addr_q.size()) checkOutput("b2b_paddr_seq", addr_q[i], i);
        end
        checkOutput("b2b_last_pwdata", pwdata, 8'h13);

        // Stuck slave: timeout abort or indefinite wait.
`ifdef APB_MASTER_TIMEOUT_EN
        applyStimulus(1'b0, 4'h9, 8'h00);
        pready = 1'b0; pslverr = 1'b0; prdata = 8'h77;
        n = 0;
        @(negedge pclk);
        while (!rsp_valid && n < 50) begin
            @(negedge pclk);
            n++;
        end
        checkOutput("to_rsp_valid", rsp_valid, 1);
        checkOutput("to_rsp_err", rsp_err, 1);
        checkOutput("to_rsp_rdata", rsp_rdata, 0);
        checkOutput("to_penable_cycles", pen_cnt, 5);
        checkOutput("to_cmd_ready", cmd_ready, 1);
        applyStimulus(1'b1, 4'h6, 8'h42);
        pready = 1'b0;
        repeat (2) @(posedge pclk);
`else
        applyStimulus(1'b0, 4'h9, 8'h00);
        pready = 1'b0; pslverr = 1'b0;
        repeat (100) @(negedge pclk);
        #1;
        checkOutput("stuck_psel", psel, 1);
        checkOutput("stuck_penable", penable, 1);
        checkOutput("stuck_cmd_ready", cmd_ready, 0);
        checkOutput("stuck_no_rsp", rsp_cnt, 0);
`endif

        // Reset while in ACCESS.
        resetMidAccess();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/apb_master.md
# apb_master

Synthesizable, parametrised APB3 master that turns a valid/ready command stream into APB transfers. It supports slave wait states (`pready`), error reporting (`pslverr`) and an optional access timeout. It sits between an internal controller or sequencer and the APB peripheral bus, and replaces the task-based stimulus driver in both RTL and integration benches.

## Interface
- `AWIDTH`, 4, APB address width.
- `DWIDTH`, 8, APB data width.
- `TIMEOUT`, 16, wait-state limit in ACCESS cycles. Must be ≥1. Only used with `APB_MASTER_TIMEOUT_EN`.

Ports:
- `pclk` in 1: clock; all logic on the rising edge.
- `presetn` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when high with `cmd_valid` at a rising edge.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in AWIDTH: transfer address.
- `cmd_wdata` in DWIDTH: write data; ignored for reads.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out DWIDTH: read data, valid with `rsp_valid`.
- `rsp_err` out 1: slave error or timeout, valid with `rsp_valid`.
- `psel`, `penable`, `pwrite` out 1: APB control.
- `paddr` out AWIDTH: APB address.
- `pwdata` out DWIDTH: APB write data.
- `prdata` in DWIDTH: APB read data.
- `pready` in 1: slave ready.
- `pslverr` in 1: slave error.

## Operation
- States: IDLE, SETUP, ACCESS.
- `cmd_ready` = (state == IDLE), decoded combinationally. No other input affects it.
- **IDLE**: on `cmd_valid && cmd_ready`, register the address, write flag and data (write data only when `cmd_write`=1; `pwdata` otherwise holds). Go to SETUP with `psel`=1 and `penable`=0.
- **SETUP**: unconditionally go to ACCESS with `penable`=1.
- **ACCESS**:
  - `pready`=0: stay in ACCESS and increment the wait counter.
  - `pready`=1: complete. Go to IDLE with `psel`=0 and `penable`=0, and set the response outputs:
    - `rsp_valid`=1 for one cycle.
    - `rsp_err` = `pslverr`.
    - `rsp_rdata` = `prdata` on a read; 0 on a write.
- `paddr`, `pwrite` and `pwdata` stay stable from SETUP through completion, and hold their last value in IDLE.
- `rsp_rdata` and `rsp_err` hold until the next completion.
- `pslverr` and `prdata` are sampled only on the completing edge.
- The wait counter clears on entry to SETUP and saturates at `TIMEOUT`. Its width is $clog2(TIMEOUT+1).
- `cmd_valid` in a non-IDLE state is ignored; the command is not consumed.
- **Reset** (async, any state, including mid-transfer):
  - State returns to IDLE immediately.
  - `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `rsp_valid`, `rsp_rdata` and `rsp_err` go to 0; `cmd_ready` goes to 1.
  - An in-flight transfer is dropped with no response.

## Timing
- Command accepted at edge E0 → SETUP visible after E0 → ACCESS (`penable`=1) after E1.
- With zero wait states, completion happens at E2: `rsp_valid` is high during the cycle after E2, concurrently with `cmd_ready`=1.
- Each wait state (`pready`=0 at an ACCESS edge) adds one cycle.
- Minimum transfer is 3 cycles. Back-to-back throughput is one transfer per 3 cycles, with the next command accepted at E3 at the earliest.
- All APB and response outputs are registered. `cmd_ready` is the only decoded output.

## Configuration
- Macro: `APB_MASTER_TIMEOUT_EN`.
- **Defined**: if ACCESS sees `pready`=0 on `TIMEOUT` consecutive edges, the next edge forces completion: go to IDLE with `psel`=`penable`=0, `rsp_valid`=1, `rsp_err`=1 and `rsp_rdata`=0. If `pready`=1 arrives on that same edge, it wins as a normal completion.
- **Undefined**: no counter logic is built and ACCESS waits indefinitely for `pready`. The `TIMEOUT` parameter is unused.

## Test plan
- **Reset values**: assert `presetn`=0 mid-ACCESS → all outputs are 0 immediately, `cmd_ready`=1, and no `rsp_valid` pulse follows.
- **Zero-wait write**: write addr 0x3 data 0xA5 with `pready`=1 → `psel` high for 2 cycles, `penable` high for 1, `paddr`=3 and `pwdata`=0xA5 stable; `rsp_valid` pulses at E2+1 with `rsp_err`=0 and `rsp_rdata`=0.
- **Read with waits**: read addr 0x7, slave holds `pready`=0 for 3 ACCESS edges and then returns `prdata`=0x5C → ACCESS lasts 4 cycles, `rsp_rdata`=0x5C, `rsp_err`=0.
- **Slave error**: write addr 0xF with `pslverr`=1 on the completing edge → `rsp_err`=1, and `rsp_err`=0 on the following good transfer.
- **Back-to-back**: `cmd_valid` held high for 4 commands → each is accepted exactly 3 cycles apart, no command is lost or duplicated, and `paddr` sequence 0, 1, 2, 3 appears on the bus.
- **Timeout** (`APB_MASTER_TIMEOUT_EN`, `TIMEOUT`=4): `pready` stuck at 0 → abort after 4 wait edges with `rsp_err`=1 and `rsp_rdata`=0, then `cmd_ready`=1. Without the macro the bench confirms the master is still in ACCESS after 100 cycles.
